// File: rtl/axil_ctrl_pkg.sv
// Shared constants and helpers for the AXI-Lite control register block.
package axil_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {CH_IDLE, CH_RESP} ch_state_e;

  // One extra index bit so STATUS and the DECERR hole above it are decodable.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // STATUS sits immediately after the last RW register.
  function automatic int status_idx(input int n);
    return n;
  endfunction

endpackage

// File: rtl/rst_release_ctr.sv
// Delayed release of an active-low core reset once enable is held high.
module rst_release_ctr #(
  parameter int DELAY = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic resetn
);

  localparam logic [15:0] LIMIT = 16'(DELAY);

  logic [15:0] cnt;

  // Counter saturates at LIMIT; dropping enable restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt    <= '0;
      resetn <= 1'b0;
    end else if (cnt == LIMIT) begin
      resetn <= 1'b1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI-Lite slave: NUM_REGS RW registers, a live status word, and core reset release.
module axil_ctrl_regs
  import axil_ctrl_pkg::*;
#(
  parameter int          NUM_REGS      = 4,
  parameter logic [31:0] REG0_RESET    = 32'h0,
  parameter int          RELEASE_DELAY = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [31:0]              s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  input  logic [31:0]              status_in,
  output logic [32*NUM_REGS-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse,
  output logic                     core_resetn
);

  localparam int               IDX_W  = idx_w(NUM_REGS);
  localparam int               RI_W   = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] ST_IDX = IDX_W'(status_idx(NUM_REGS));

  logic [NUM_REGS-1:0][31:0] regs;
  logic [IDX_W-1:0]          widx, ridx;
  logic                      wr_acc, rd_acc;
  logic [1:0]                wresp, rresp_nxt;
  logic [31:0]               rdata_nxt;
  ch_state_e                 wstate, wnext, rstate, rnext;

  assign widx     = s_axil_awaddr[IDX_W+1:2];
  assign ridx     = s_axil_araddr[IDX_W+1:2];
  assign regs_out = regs;

  assign wr_acc = s_axil_awvalid && s_axil_wvalid && !s_axil_awready &&
                  (!s_axil_bvalid || s_axil_bready);
  assign rd_acc = s_axil_arvalid && !s_axil_arready &&
                  (!s_axil_rvalid || s_axil_rready);

  always_comb begin
    wresp = RESP_DECERR;
    if (widx < ST_IDX)       wresp = RESP_OKAY;
    else if (widx == ST_IDX) wresp = RESP_SLVERR;
  end

  always_comb begin
    rdata_nxt = '0;
    rresp_nxt = RESP_DECERR;
    if (ridx < ST_IDX) begin
      rdata_nxt = regs[ridx[RI_W-1:0]];
      rresp_nxt = RESP_OKAY;
    end else if (ridx == ST_IDX) begin
      rdata_nxt = status_in;
      rresp_nxt = RESP_OKAY;
    end
  end

  // Channel FSMs: RESP state is the pending-response (valid) flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= CH_IDLE;
      rstate <= CH_IDLE;
    end else begin
      wstate <= wnext;
      rstate <= rnext;
    end
  end

  always_comb begin
    wnext = wstate;
    rnext = rstate;
    s_axil_bvalid = (wstate == CH_RESP);
    s_axil_rvalid = (rstate == CH_RESP);
    if (wr_acc)                               wnext = CH_RESP;
    else if (wstate == CH_RESP && s_axil_bready) wnext = CH_IDLE;
    if (rd_acc)                               rnext = CH_RESP;
    else if (rstate == CH_RESP && s_axil_rready) rnext = CH_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      reg_wr_pulse   <= '0;
      regs           <= '0;
      regs[0]        <= REG0_RESET;
    end else begin
      s_axil_awready <= wr_acc;
      s_axil_wready  <= wr_acc;
      reg_wr_pulse   <= '0;
      if (wr_acc) begin
        s_axil_bresp <= wresp;
        if (wresp == RESP_OKAY) begin
          reg_wr_pulse[widx[RI_W-1:0]] <= 1'b1;
          for (int k = 0; k < 4; k++)
            if (s_axil_wstrb[k])
              regs[widx[RI_W-1:0]][8*k +: 8] <= s_axil_wdata[8*k +: 8];
        end
      end
    end
  end

  // Read data is latched from pre-write register contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
    end else begin
      s_axil_arready <= rd_acc;
      if (rd_acc) begin
        s_axil_rdata <= rdata_nxt;
        s_axil_rresp <= rresp_nxt;
      end
    end
  end

  rst_release_ctr #(.DELAY(RELEASE_DELAY)) u_release (
    .clk    (clk),
    .rst    (rst),
    .enable (regs[0][0]),
    .resetn (core_resetn)
  );

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs: vector table plus multi-cycle sequences.
module tb_axil_ctrl_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  awaddr, wdata, araddr, status_in;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] regs_out;
  logic [3:0]   reg_wr_pulse;
  logic         core_resetn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_ctrl_regs #(.NUM_REGS(4), .REG0_RESET(32'h0), .RELEASE_DELAY(16)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .status_in(status_in), .regs_out(regs_out), .reg_wr_pulse(reg_wr_pulse),
    .core_resetn(core_resetn)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
    logic [3:0]  pulse;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at posedge+1 of the accept edge with valids already dropped.
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic br, output bit ok);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = br; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) begin ok = 1'b1; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wr_timeout addr %0h: got no awready expected awready", a);
    end
  endtask

  task automatic rd_issue(input logic [31:0] a, input logic rr, output bit ok);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = rr; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) begin ok = 1'b1; break; end
    end
    arvalid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rd_timeout addr %0h: got no arready expected arready", a);
    end
  endtask

  task automatic wait_rise(input string name, input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (core_resetn) begin n = i; break; end
    end
    chk(name, n, exp_edges);
  endtask

  initial begin
    bit ok;
    int ar_cnt, aw_cnt, bv_low;
    bit rose;

    tbl[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'b0101, 32'h0,        2'b00, 4'b0010};
    tbl[1]  = '{1'b0, 32'h04, 32'h0,        4'b0000, 32'h00AD00EF, 2'b00, 4'b0000};
    tbl[2]  = '{1'b1, 32'h08, 32'h11223344, 4'b1111, 32'h0,        2'b00, 4'b0100};
    tbl[3]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'b1000, 32'h0,        2'b00, 4'b0100};
    tbl[4]  = '{1'b0, 32'h08, 32'h0,        4'b0000, 32'hAA223344, 2'b00, 4'b0000};
    tbl[5]  = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0000, 32'h0,        2'b00, 4'b1000};
    tbl[6]  = '{1'b0, 32'h0C, 32'h0,        4'b0000, 32'h0,        2'b00, 4'b0000};
    tbl[7]  = '{1'b0, 32'h10, 32'h0,        4'b0000, 32'h12345678, 2'b00, 4'b0000};
    tbl[8]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b10, 4'b0000};
    tbl[9]  = '{1'b0, 32'h14, 32'h0,        4'b0000, 32'h0,        2'b11, 4'b0000};
    tbl[10] = '{1'b1, 32'h1C, 32'h55555555, 4'b1111, 32'h0,        2'b11, 4'b0000};
    tbl[11] = '{1'b0, 32'h04, 32'h0,        4'b0000, 32'h00AD00EF, 2'b00, 4'b0000};
    tbl[12] = '{1'b0, 32'h11, 32'h0,        4'b0000, 32'h12345678, 2'b00, 4'b0000};
    tbl[13] = '{1'b0, 32'h24, 32'h0,        4'b0000, 32'h00AD00EF, 2'b00, 4'b0000};

    rst = 1'b1; awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; status_in = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("reset_ready", {awready, wready, arready}, 3'b000);
    chk("reset_valid", {bvalid, rvalid}, 2'b00);
    chk("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("reset_regs", regs_out, 128'h0);
    chk("reset_pulse_core", {reg_wr_pulse, core_resetn}, 5'b0);

    for (int v = 0; v < 14; v++) begin
      if (tbl[v].wr) begin
        wr_issue(tbl[v].addr, tbl[v].data, tbl[v].strb, 1'b1, ok);
        chk($sformatf("v%0d_bvalid", v), bvalid, 1'b1);
        chk($sformatf("v%0d_bresp", v), bresp, tbl[v].resp);
        chk($sformatf("v%0d_pulse", v), reg_wr_pulse, tbl[v].pulse);
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse_end", v), reg_wr_pulse, 4'b0);
        chk($sformatf("v%0d_bclear", v), bvalid, 1'b0);
      end else begin
        rd_issue(tbl[v].addr, 1'b1, ok);
        chk($sformatf("v%0d_rvalid", v), rvalid, 1'b1);
        chk($sformatf("v%0d_rdata", v), rdata, tbl[v].exp);
        chk($sformatf("v%0d_rresp", v), rresp, tbl[v].resp);
      end
    end
    chk("regs_after_table", regs_out, {32'h0, 32'hAA223344, 32'h00AD00EF, 32'h0});

    // Core release after setting reg0[0], then fall after clearing it.
    wr_issue(32'h0, 32'h1, 4'b0001, 1'b1, ok);
    wait_rise("release_17", 17);
    wr_issue(32'h0, 32'h0, 4'b0001, 1'b1, ok);
    chk("fall_at_accept", core_resetn, 1'b1);
    @(posedge clk); #1;
    chk("fall_next_edge", core_resetn, 1'b0);

    // Abort mid-count, then a fresh release.
    wr_issue(32'h0, 32'h1, 4'b0001, 1'b1, ok);
    repeat (4) @(posedge clk);
    wr_issue(32'h0, 32'h0, 4'b0001, 1'b1, ok);
    rose = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (core_resetn) rose = 1'b1;
    end
    chk("abort_no_rise", rose, 1'b0);
    wr_issue(32'h0, 32'h1, 4'b0001, 1'b1, ok);
    wait_rise("rerelease_17", 17);

    // bready stall: reads keep flowing, second write is held off.
    wr_issue(32'h8, 32'h0BADF00D, 4'b1111, 1'b0, ok);
    @(negedge clk);
    awaddr = 32'hC; wdata = 32'hCAFEF00D; wstrb = 4'b1111; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4; arvalid = 1'b1; rready = 1'b1;
    ar_cnt = 0; aw_cnt = 0; bv_low = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (arready) ar_cnt++;
      if (awready) aw_cnt++;
      if (!bvalid) bv_low++;
    end
    arvalid = 1'b0;
    chk("stall_reads", ar_cnt, 5);
    chk("stall_no_write", aw_cnt, 0);
    chk("stall_bvalid_held", bv_low, 0);
    chk("stall_rdata", rdata, 32'h00AD00EF);
    @(negedge clk); bready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_accept", awready, 1'b1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    chk("stall_regs", regs_out[127:64], {32'hCAFEF00D, 32'h0BADF00D});

    // Reset with both responses pending.
    wr_issue(32'h4, 32'h01020304, 4'b1111, 1'b0, ok);
    rd_issue(32'h4, 1'b0, ok);
    chk("pending_valids", {bvalid, rvalid, core_resetn}, 3'b111);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_regs", regs_out, 128'h0);
    chk("rst_core", core_resetn, 1'b0);
    @(negedge clk); rst = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_idle", {bvalid, rvalid, core_resetn}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_ctrl_regs.md
# axil_ctrl_regs

Parametrised AXI-Lite control/status register slave, the generalised successor to the single write-only GPIO word used for core-reset control in the RISC-V tile. It provides NUM_REGS read/write 32-bit registers with byte strobes, a read-only status word, and error responses. It also generates a delayed core-release reset (`core_resetn`) from register 0 bit 0. It sits on the external-side AXI-Lite interconnect master port, behind the UMI-to-AXI bridge.

## Interface
- NUM_REGS, 4, number of RW registers; power of two, 2..64.
- REG0_RESET, 32'h0, reset value of register 0; registers 1..NUM_REGS-1 reset to 0.
- RELEASE_DELAY, 16, extra cycles between reg0[0] rising and `core_resetn` rising; 0..65535.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_axil_awaddr  in  32  write address.
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake.
- s_axil_araddr  in  32  read address.
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake.
- status_in  in  32  live status word, readable at index NUM_REGS.
- regs_out  out  32*NUM_REGS  flat register contents; reg i occupies bits [32i+31:32i].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register written.
- core_resetn  out  1  active-low reset for the attached core.

## Operation
- Decode: idx = addr[IDX_W+1:2], where IDX_W = clog2(NUM_REGS)+1. addr[1:0] and bits above the index are ignored; the interconnect does the base decode.
- Decode regions:
  - idx < NUM_REGS: RW register, OKAY (2'b00).
  - idx == NUM_REGS: STATUS. Reads return status_in sampled at the accept edge, OKAY. Writes have no effect and return SLVERR (2'b10).
  - idx > NUM_REGS: DECERR (2'b11). Read data is 0; writes have no effect.
- Write accept edge: occurs when awvalid && wvalid && !awready && (!bvalid || bready). At that edge:
  - byte k of the target register is updated iff wstrb[k];
  - awready and wready are set for exactly one cycle;
  - bvalid is set and bresp is latched;
  - the matching reg_wr_pulse bit is set for one cycle (OKAY writes only, including writes with wstrb = 0).
- bvalid clears on bvalid && bready.
- Read accept edge: occurs when arvalid && !arready && (!rvalid || rready). At that edge rdata/rresp are latched, arready is set for one cycle, and rvalid is set. rvalid clears on rvalid && rready.
- Read and write channels are independent. A read and a write to the same register accepted at the same edge returns the pre-write value.
- Core release:
  - When reg0[0] == 0, the counter clears and `core_resetn` goes 0 on the next edge.
  - When reg0[0] == 1, the counter increments until it equals RELEASE_DELAY, then `core_resetn` goes 1.
  - Clearing reg0[0] mid-count aborts the release and restarts the count from 0.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, reg_wr_pulse, and core_resetn are all 0. bresp, rresp, and rdata are 0. Registers take their reset values. If REG0_RESET[0] = 1, `core_resetn` rises RELEASE_DELAY+1 cycles after rst deasserts.
- Write: bvalid is visible 1 cycle after valids are seen (B-channel latency 1). Sustained throughput is 1 write per 2 cycles with bready held high.
- Read latency: rvalid is visible 1 cycle after arvalid is seen. Sustained throughput is 1 read per 2 cycles.
- A stalled bready or rready blocks further accepts on that channel only.
- `core_resetn` rises exactly RELEASE_DELAY+1 edges after the accept edge of a write setting reg0[0]. It falls 1 edge after the accept edge clearing reg0[0].
- rst asserted mid-transaction drops all pending responses, with no response issued. The master is also reset by the same rst.

## Structure
- Shared package `axil_ctrl_pkg`:
  - response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - IDX_W function;
  - STATUS index localparam rule.
- Sub-module `rst_release_ctr`:
  - parameter DELAY;
  - ports clk, rst, enable, resetn;
  - 16-bit saturating counter.
- The top module holds the decode, the register array, and both channel handshake FSMs (IDLE/RESP each).

## Test plan
- After reset, NUM_REGS=4: write 0xDEADBEEF to 0x4 with wstrb 4'b0101, then read 0x4 -> rdata 0x00AD00EF, rresp 0, reg_wr_pulse = 4'b0010 for one cycle.
- Write 1 to 0x0 with RELEASE_DELAY=16 -> `core_resetn` rises exactly 17 cycles after the accept edge. Write 0 -> it falls 1 edge later.
- Write 1, then write 0 at count 5 -> `core_resetn` never rises. Write 1 again -> it rises 17 cycles after that accept edge.
- With status_in=0x12345678: read 0x10 -> rdata 0x12345678, OKAY. Write 0x10 -> SLVERR, regs unchanged. Read 0x14 -> DECERR, rdata 0.
- Hold bready low 10 cycles after a write, while back-to-back reads with rready=1 complete every 2 cycles. A second write is not accepted until bready.
- Assert rst while bvalid and rvalid are high -> both are 0 on the next cycle, regs_out returns to reset values, and `core_resetn` is 0.
